// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select stage:
// load size encodings and the saturating error-count increment.
package wb_pkg;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;
  localparam logic [1:0] LS_RSVD = 2'b11;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] cnt
  );
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/half lane extraction with sign or zero extension.
// Ports: data, load_size, load_signed, byte_off in; ext out.
module load_extend
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       load_size,
  input  logic             load_signed,
  input  logic [1:0]       byte_off,
  output logic [WIDTH-1:0] ext
);

  // Pad narrow words so every byte lane index stays in range.
  localparam int PW = (WIDTH < 32) ? 32 : WIDTH;

  logic [PW-1:0] wide;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  assign wide   = PW'(data);
  assign lane_b = wide[8*byte_off +: 8];
  assign lane_h = wide[16*byte_off[1] +: 16];

  always_comb begin
    ext = data;
    case (load_size)
      LS_BYTE: begin
        ext = {WIDTH{load_signed & lane_b[7]}};
        ext[7:0] = lane_b;
      end
      LS_HALF: begin
        ext = {WIDTH{load_signed & lane_h[15]}};
        ext[15:0] = lane_h;
      end
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/wb_select_reg.sv
// Registered write-back source select with load extension,
// stall/flush, out-of-range select error and saturating count.
module wb_select_reg
  import wb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3,
  parameter int MEM_SRC = 1,
  parameter int ADDR_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [1:0]               load_size,
  input  logic                     load_signed,
  input  logic [1:0]               byte_off,
  input  logic [ADDR_W-1:0]        dest_addr,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_we,
  output logic                     sel_err,
  output logic [7:0]               err_count
);

  logic [WIDTH-1:0] mem_ext;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             capture;

  load_extend #(
    .WIDTH(WIDTH)
  ) u_ext (
    .data       (src_data[MEM_SRC*WIDTH +: WIDTH]),
    .load_size  (load_size),
    .load_signed(load_signed),
    .byte_off   (byte_off),
    .ext        (mem_ext)
  );

  // Extra bit keeps the compare right when NUM_SRC == 2**SEL_W.
  assign sel_oob = {1'b0, sel} >= (SEL_W+1)'(NUM_SRC);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = (k == MEM_SRC) ? mem_ext
                 : src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign capture = !flush && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      sel_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_data  <= sel_data;
      out_addr  <= dest_addr;
      sel_err   <= in_valid && sel_oob;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (capture && in_valid && sel_oob) begin
      err_count <= sat_inc(err_count);
    end
  end

  assign out_we = out_valid && (out_addr != '0);

endmodule

// File: tb/tb_wb_select_reg.sv
// Directed self-checking bench for wb_select_reg.
// One task per scenario, inline comparisons.
module tb_wb_select_reg;

  localparam int W = 32;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         stall;
  logic         flush;
  logic [2:0]   sel;
  logic [N*W-1:0] src_data;
  logic [1:0]   load_size;
  logic         load_signed;
  logic [1:0]   byte_off;
  logic [4:0]   dest_addr;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [4:0]   out_addr;
  logic         out_we;
  logic         sel_err;
  logic [7:0]   err_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_select_reg dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .sel        (sel),
    .src_data   (src_data),
    .load_size  (load_size),
    .load_signed(load_signed),
    .byte_off   (byte_off),
    .dest_addr  (dest_addr),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_we     (out_we),
    .sel_err    (sel_err),
    .err_count  (err_count)
  );

  task automatic set_src(input int k, input logic [W-1:0] v);
    src_data[k*W +: W] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    sel = 3'd0; src_data = '0; load_size = 2'b00;
    load_signed = 1'b0; byte_off = 2'd0; dest_addr = 5'd0;
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 ||
        out_addr !== 5'd0) begin
      fails++;
      $display("FAIL reset_regs valid=%b data=%h addr=%h want 0",
               out_valid, out_data, out_addr);
    end
    tests++;
    if (out_we !== 1'b0 || sel_err !== 1'b0 ||
        err_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_misc we=%b err=%b cnt=%0d want 0",
               out_we, sel_err, err_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word();
    for (int k = 0; k < N; k++) set_src(k, 32'h1000_0000 + k);
    set_src(3, 32'hDEAD_BEEF);
    sel = 3'd3; dest_addr = 5'd5; in_valid = 1'b1;
    tick();
    tests++;
    if (out_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL word_data got %h want deadbeef", out_data);
    end
    tests++;
    if (out_valid !== 1'b1 || out_we !== 1'b1 ||
        out_addr !== 5'd5) begin
      fails++;
      $display("FAIL word_ctl valid=%b we=%b addr=%0d want 1 1 5",
               out_valid, out_we, out_addr);
    end
  endtask

  task automatic test_extend();
    logic [1:0]  sz [7];
    logic        sg [7];
    logic [1:0]  off[7];
    logic [2:0]  s  [7];
    logic [31:0] exp[7];
    sz = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10};
    sg = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    off = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
    s  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
    exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234,
            32'h0000_5680, 32'h0000_0056, 32'h1234_5680,
            32'hCAFE_F00D};
    set_src(1, 32'h1234_5680);
    set_src(2, 32'hCAFE_F00D);
    dest_addr = 5'd7;
    for (int i = 0; i < 7; i++) begin
      sel = s[i]; load_size = sz[i];
      load_signed = sg[i]; byte_off = off[i];
      in_valid = 1'b1;
      tick();
      tests++;
      if (out_data !== exp[i] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL extend_%0d got %h v=%b want %h v=1",
                 i, out_data, out_valid, exp[i]);
      end
    end
    set_src(1, 32'h8765_4321);
    sel = 3'd1; load_size = 2'b01;
    load_signed = 1'b1; byte_off = 2'd3;
    tick();
    tests++;
    if (out_data !== 32'hFFFF_8765) begin
      fails++;
      $display("FAIL extend_neg_half got %h want ffff8765",
               out_data);
    end
    load_size = 2'b00; load_signed = 1'b0; byte_off = 2'd0;
  endtask

  task automatic test_back_to_back();
    set_src(3, 32'hAAAA_0003);
    set_src(2, 32'hBBBB_0002);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = (i % 2 == 0) ? 3'd3 : 3'd2;
      dest_addr = 5'(10 + i);
      tick();
      tests++;
      if (out_valid !== 1'b1 ||
          out_data !== ((i % 2 == 0) ? 32'hAAAA_0003
                                     : 32'hBBBB_0002) ||
          out_addr !== 5'(10 + i)) begin
        fails++;
        $display("FAIL b2b_%0d v=%b data=%h addr=%0d", i,
                 out_valid, out_data, out_addr);
      end
    end
  endtask

  task automatic test_out_of_range();
    sel = 3'd7; in_valid = 1'b1; dest_addr = 5'd4;
    tick();
    stall = 1'b1;
    tick();
    tests++;
    if (err_count !== 8'd1 || sel_err !== 1'b1) begin
      fails++;
      $display("FAIL oob_stall cnt=%0d err=%b want 1 1",
               err_count, sel_err);
    end
    stall = 1'b0;
    tick();
    tests++;
    if (out_data !== 32'h0 || sel_err !== 1'b1 ||
        err_count !== 8'd2) begin
      fails++;
      $display("FAIL oob_three data=%h err=%b cnt=%0d want 0 1 2",
               out_data, sel_err, err_count);
    end
    sel = 3'd6;
    tick();
    tests++;
    if (err_count !== 8'd3 || sel_err !== 1'b1) begin
      fails++;
      $display("FAIL oob_sel6 cnt=%0d err=%b want 3 1",
               err_count, sel_err);
    end
    for (int i = 0; i < 297; i++) tick();
    tests++;
    if (err_count !== 8'd255) begin
      fails++;
      $display("FAIL oob_saturate cnt=%0d want 255", err_count);
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (sel_err !== 1'b0 || out_valid !== 1'b0 ||
        err_count !== 8'd255) begin
      fails++;
      $display("FAIL oob_idle err=%b v=%b cnt=%0d want 0 0 255",
               sel_err, out_valid, err_count);
    end
  endtask

  task automatic test_stall_flush();
    sel = 3'd3; set_src(3, 32'h0A0A_0A0A);
    dest_addr = 5'd9; in_valid = 1'b1;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_src(3, 32'h5000_0000 + i);
      dest_addr = 5'(20 + i);
      in_valid = i[0];
      tick();
      tests++;
      if (out_data !== 32'h0A0A_0A0A || out_valid !== 1'b1 ||
          out_addr !== 5'd9) begin
        fails++;
        $display("FAIL stall_%0d data=%h v=%b addr=%0d", i,
                 out_data, out_valid, out_addr);
      end
    end
    flush = 1'b1; in_valid = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_we !== 1'b0 ||
        sel_err !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall v=%b we=%b err=%b want 0",
               out_valid, out_we, sel_err);
    end
    stall = 1'b0; flush = 1'b0;
    set_src(3, 32'h0B0B_0B0B);
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h0B0B_0B0B) begin
      fails++;
      $display("FAIL resume v=%b data=%h want 1 0b0b0b0b",
               out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    sel = 3'd3; set_src(3, 32'h1111_2222);
    dest_addr = 5'd3; in_valid = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 ||
        out_addr !== 5'd0 || err_count !== 8'd0 ||
        out_we !== 1'b0) begin
      fails++;
      $display("FAIL async_reset v=%b d=%h a=%0d cnt=%0d we=%b",
               out_valid, out_data, out_addr, err_count, out_we);
    end
    tick();
    @(negedge clk);
    reset = 1'b1;
    set_src(3, 32'h3333_4444);
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h3333_4444) begin
      fails++;
      $display("FAIL post_reset v=%b data=%h want 1 33334444",
               out_valid, out_data);
    end
  endtask

  task automatic test_addr_zero();
    sel = 3'd0; set_src(0, 32'h0000_00AA);
    dest_addr = 5'd0; in_valid = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_we !== 1'b0) begin
      fails++;
      $display("FAIL addr_zero v=%b we=%b want 1 0",
               out_valid, out_we);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_back_to_back();
    test_out_of_range();
    test_stall_flush();
    test_reset_mid();
    test_addr_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_select_reg.md
# wb_select_reg

Parametrised, registered write-back selector for the multicycle datapath. It picks one of `NUM_SRC` candidate write-data sources and applies byte/halfword extraction with sign or zero extension when the memory source is chosen. It then registers the result together with the destination register address as a one-stage pipeline with stall and flush. It sits between the datapath source buses and the register file write port.

## Interface
Parameters:
- `WIDTH`, 32: data width; must be a multiple of 16.
- `NUM_SRC`, 6: number of write-data sources; range 2..8.
- `SEL_W`, 3: selector width; `2**SEL_W >= NUM_SRC` is required.
- `MEM_SRC`, 1: index of the memory-data source, the only source that is extended.
- `ADDR_W`, 5: register file address width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input bundle valid this cycle.
- `stall`, in, 1: hold all output registers.
- `flush`, in, 1: kill the registered result.
- `sel`, in, `SEL_W`: source index.
- `src_data`, in, `NUM_SRC*WIDTH`: flattened sources; source k is `src_data[k*WIDTH +: WIDTH]`.
- `load_size`, in, 2: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- `load_signed`, in, 1: 1 selects sign extension, 0 selects zero extension.
- `byte_off`, in, 2: byte offset of the load within the word.
- `dest_addr`, in, `ADDR_W`: destination register.
- `out_valid`, out, 1: registered result valid.
- `out_data`, out, `WIDTH`: registered write data.
- `out_addr`, out, `ADDR_W`: registered destination.
- `out_we`, out, 1: register-file write enable, equal to `out_valid && out_addr != 0`.
- `sel_err`, out, 1: registered pulse; the captured `sel` was `>= NUM_SRC`.
- `err_count`, out, 8: saturating count of `sel_err` events.

## Operation
- Combinational select: `sel < NUM_SRC` passes source `sel`. An out-of-range `sel` gives data 0 and raises the error.
- Extension applies only when `sel == MEM_SRC`:
  - Byte: lane `byte_off` (bits `8*byte_off +: 8`).
  - Half: lane `byte_off[1]`; `byte_off[0]` is ignored, and misalignment is not flagged.
  - Word or reserved: passed through unchanged.
  - Extension to `WIDTH` follows `load_signed`.
- When `sel != MEM_SRC`, `load_size`, `load_signed` and `byte_off` are ignored.
- Register update priority per edge, highest first:
  1. `reset` low (asynchronous): all outputs and `err_count` are 0.
  2. `flush`: `out_valid` and `sel_err` go to 0. Data and address are don't-care but held. `err_count` is unchanged. Flush wins over `stall`.
  3. `stall`: all registers hold, including the `sel_err` level. The input is not consumed, so upstream must hold it.
  4. Otherwise the registers load the input:
     - `out_valid <= in_valid`.
     - `out_data` and `out_addr` load the new values.
     - `sel_err <= in_valid && sel >= NUM_SRC`.
- `err_count` increments when a valid out-of-range input is captured and saturates at 255. Flushed or stalled cycles never count.
- `out_we` is combinational from the registers. It never asserts for address 0.

## Timing
- Latency: 1 cycle from input capture to `out_*`.
- Throughput: 1 per cycle when not stalled.
- Reset value of every output: 0.
- Reset release mid-stream: the first capture happens on the first edge with `reset` high.
- Stall held for N cycles keeps outputs constant for N cycles. Capture resumes on the first unstalled edge.
- `flush` together with `in_valid`: the input is dropped and `out_valid` is 0 next cycle.
- Back-to-back valid inputs with alternating `sel` produce back-to-back results with no bubbles.

## Structure
- Shared package `wb_pkg`:
  - Load size encodings `LS_WORD`, `LS_HALF`, `LS_BYTE`, `LS_RSVD`.
  - A function computing the saturating increment.
- Sub-module `load_extend`: combinational; inputs `data`, `load_size`, `load_signed`, `byte_off`; output the extended word. Instantiated once on the `MEM_SRC` path.
- Top level: selection loop, registers, error counter.

## Test plan
- Word select: `NUM_SRC=6`, sel=3, src3=0xDEADBEEF, `in_valid`=1 -> next cycle `out_data`=0xDEADBEEF, `out_valid`=1, and `out_we`=1 with addr=5.
- Signed byte: sel=MEM_SRC, mem=0x12345680, byte, `load_signed`=1, off=0 -> 0xFFFFFF80. Same stimulus with `load_signed`=0 -> 0x00000080. Half, signed, off=3 -> 0x00001234.
- Out of range: sel=7 with `in_valid` for 3 cycles, with one of them stalled -> `out_data`=0, `sel_err`=1, and `err_count`=2. Continue to 300 errors -> `err_count` stays at 255.
- Stall/flush: capture A, stall 4 cycles with a changing input -> outputs stay at A. Assert flush and stall together -> `out_valid`=0 next cycle.
- Reset mid-stream: assert `reset` low between edges while `out_valid`=1 -> all outputs 0 immediately without waiting for an edge. After release, the next input appears after 1 cycle.
- Address zero: `dest_addr`=0 with a valid input -> `out_valid`=1 and `out_we`=0.
